esn7e_run_ctrl: RTL
===================

ESN7E_RUN_CTRL -- requirements
Module: esn7e_run_ctrl

Interface
REQ-001 SHALL provide parameter DW, default 32, width of ESN sample word and stream data.
REQ-002 SHALL provide parameter CW, default 16, width of sample-length and sample counters.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle run request.
REQ-006 SHALL have port stop  in  1  one-cycle abort request.
REQ-007 SHALL have port num_samples  in  CW  run length in words; 0 means continuous; sampled on accepted start.
REQ-008 SHALL have port esn_ce  out  1  clock enable to ESN core.
REQ-009 SHALL have port esn_valid  in  1  ESN readout-valid strobe.
REQ-010 SHALL have port esn_data  in  DW  packed ESN word {input, yhat}.
REQ-011 SHALL have port src_valid / src_ready  out/in  1/1  Avalon-ST source handshake.
REQ-012 SHALL have port src_data  out  DW  stream word.
REQ-013 SHALL have ports src_sop / src_eop  out  1/1  packet delimiters, qualified by src_valid.
REQ-014 SHALL have ports busy, start_err, aborted  out  1 each  status; start_err and aborted sticky.
REQ-015 SHALL have port sample_count  out  CW  words accepted in current or last run.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 IDLE->RUN on start while stop low; SHALL latch num_samples, clear sample_count, start_err, aborted.
REQ-018 start while in RUN or DRAIN SHALL be ignored and SHALL set start_err.
REQ-019 start and stop in the same cycle SHALL be treated as stop only; in IDLE it has no effect.
REQ-020 SHALL contain a 2-entry FIFO (data, sop, eop) between ESN and source port.
REQ-021 esn_ce SHALL be registered, high only in RUN with FIFO occupancy (next cycle) < 2, so an accepted word always has space.
REQ-022 A word SHALL be accepted only when esn_valid and esn_ce are both high in the same cycle; esn_valid with esn_ce low SHALL be ignored.
REQ-023 First accepted word of a run SHALL carry sop=1; all others sop=0.
REQ-024 With num_samples=N>0, accepted word N SHALL carry eop=1, and FSM SHALL go RUN->DRAIN the same cycle; esn_ce low next cycle.
REQ-025 With num_samples=0, RUN SHALL continue until stop; sample_count SHALL wrap 2^CW-1 -> 0 without side effect.
REQ-026 stop in RUN SHALL go to DRAIN, drop esn_ce next cycle, and set eop on the newest FIFO entry if occupancy >0; if FIFO empty SHALL set aborted.
REQ-027 A word accepted in the same cycle as stop SHALL be stored and SHALL itself carry eop=1.
REQ-028 Word at FIFO head SHALL be transferred when src_valid and src_ready high; FIFO SHALL support simultaneous push and pop.
REQ-029 src_valid SHALL equal FIFO non-empty; src_data/sop/eop SHALL be stable while src_valid high and src_ready low.
REQ-030 DRAIN->IDLE when FIFO empty; busy SHALL be high in RUN and DRAIN.
REQ-031 Latency esn_valid accept -> src_valid SHALL be 1 cycle when FIFO empty.

Reset
REQ-032 On reset_n low: state IDLE, FIFO empty, esn_ce=0, src_valid=0, src_sop=0, src_eop=0, src_data=0, busy=0, start_err=0, aborted=0, sample_count=0.
REQ-033 Reset asserted mid-run SHALL discard buffered words immediately; no eop SHALL be emitted afterward.

Verification
REQ-034 N=4, src_ready=1, esn_valid every cycle -> exactly 4 words, sop on 1st, eop on 4th, busy falls 1 cycle after last transfer, sample_count=4.
REQ-035 N=8, src_ready low 10 cycles mid-run -> esn_ce low within 1 cycle of FIFO full, no word lost or duplicated, data order preserved.
REQ-036 N=0, stop after 5 accepted words with FIFO holding 1 word -> that word has eop=1, aborted=0; stop with FIFO empty -> aborted=1, no eop.
REQ-037 start during RUN -> start_err=1, run length unchanged; start+stop same cycle in RUN -> DRAIN, start_err unchanged.
REQ-038 reset_n pulsed low with 2 words buffered -> all outputs at REQ-032 values same cycle, next start yields a clean sop packet.

Source files
------------

// File: rtl/esn7e_run_ctrl.sv
// Run controller: gates the ESN core clock enable and streams its readout words out over Avalon-ST with sop/eop framing.
// Latency: one cycle from an accepted esn_valid word to src_valid when the output buffer is empty.
// Backpressure: a 2-entry buffer absorbs src_ready stalls; esn_ce drops as soon as the buffer is full, so no word is lost.
module esn7e_run_ctrl #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] num_samples,
    output logic          esn_ce,
    input  logic          esn_valid,
    input  logic [DW-1:0] esn_data,
    output logic          src_valid,
    input  logic          src_ready,
    output logic [DW-1:0] src_data,
    output logic          src_sop,
    output logic          src_eop,
    output logic          busy,
    output logic          start_err,
    output logic          aborted,
    output logic [CW-1:0] sample_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        head_q, head_d;     // oldest buffered word, drives the source port
    entry_t        tail_q, tail_d;     // second word, valid only when occupancy is 2
    logic [1:0]    cnt_q, cnt_d;
    logic          ce_q, ce_d;
    logic          first_q, first_d;   // next accepted word opens the packet
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic          start_err_q, start_err_d;
    logic          aborted_q, aborted_d;

    logic          acc;
    logic          pop;
    logic          start_ok;
    logic          stop_run;
    logic          last;
    entry_t        new_e;

    // esn_ce is only ever high in RUN with a free slot, so acc alone implies a legal push.
    assign acc      = esn_valid & ce_q;
    assign pop      = (cnt_q != 2'd0) & src_ready;
    // A simultaneous stop wins over start in every state.
    assign start_ok = (state_q == IDLE) & start & ~stop;
    assign stop_run = (state_q == RUN) & stop;
    assign last     = acc & (len_q != '0) & (scnt_q == len_q - CW'(1));

    assign new_e.data = esn_data;
    assign new_e.sop  = first_q;
    assign new_e.eop  = last | stop_run;

    // Buffer update: shift-style 2-entry queue, then close the packet on the newest surviving word after a stop.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({acc, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = new_e;
                end else begin
                    tail_d = new_e;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = new_e;
                end else begin
                    head_d = tail_q;
                    tail_d = new_e;
                end
            end
            default: ;
        endcase
        // A word leaving in the stop cycle cannot be re-marked, so only what remains afterwards counts.
        if (stop_run && !acc && (cnt_d != 2'd0)) begin
            if (cnt_d == 2'd2) begin
                tail_d.eop = 1'b1;
            end else begin
                head_d.eop = 1'b1;
            end
        end
    end

    // Run sequencing: IDLE -> RUN on start, RUN -> DRAIN on stop or final word, DRAIN -> IDLE once empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (stop_run || last) state_d = DRAIN;
            DRAIN:   if (cnt_q == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Run bookkeeping: clock enable, run length, counters and sticky status flags.
    always_comb begin
        ce_d        = (state_d == RUN) && (cnt_d != 2'd2);
        len_d       = start_ok ? num_samples : len_q;
        scnt_d      = scnt_q;
        first_d     = first_q;
        start_err_d = start_err_q;
        aborted_d   = aborted_q;
        if (start_ok) begin
            scnt_d      = '0;
            first_d     = 1'b1;
            start_err_d = 1'b0;
            aborted_d   = 1'b0;
        end else begin
            if (acc) begin
                scnt_d  = scnt_q + CW'(1);
                first_d = 1'b0;
            end
            if (start && !stop && (state_q != IDLE)) begin
                start_err_d = 1'b1;
            end
            // Nothing left to carry the eop, so the run is flagged as aborted instead.
            if (stop_run && !acc && (cnt_d == 2'd0)) begin
                aborted_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any buffered words immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= 2'd0;
            ce_q        <= 1'b0;
            first_q     <= 1'b0;
            len_q       <= '0;
            scnt_q      <= '0;
            start_err_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            first_q     <= first_d;
            len_q       <= len_d;
            scnt_q      <= scnt_d;
            start_err_q <= start_err_d;
            aborted_q   <= aborted_d;
        end
    end

    assign esn_ce       = ce_q;
    assign src_valid    = (cnt_q != 2'd0);
    assign src_data     = head_q.data;
    assign src_sop      = head_q.sop & src_valid;
    assign src_eop      = head_q.eop & src_valid;
    assign busy         = (state_q != IDLE);
    assign start_err    = start_err_q;
    assign aborted      = aborted_q;
    assign sample_count = scnt_q;

endmodule
